// File: rtl/ym3438_host_pkg.sv
// Shared types and constants for the ym3438 host-side write initiator.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ym3438_host_pkg;

  // Top-level transaction state.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_POLL,
    ST_POLL_GAP
  } state_e;

  // Kind of bus phase the strobe sequencer runs.
  typedef enum logic [1:0] {
    PH_WR_ADDR,
    PH_WR_DATA,
    PH_RD_STATUS
  } phase_e;

  // Busy flag position in the chip status byte.
  localparam int BUSY_BIT = 7;

  // A0 selects address (0) or data (1) register of the addressed bank.
  localparam logic ADDR_A0_ADDR = 1'b0;
  localparam logic ADDR_A0_DATA = 1'b1;

endpackage

// File: rtl/ym3438_bus_strobe.sv
// Single bus-phase sequencer: setup, strobe pulse, hold, optional CS-high gap.
// Latency: outputs registered; phase lasts SETUP+PULSE+1(+GAP) cycles from the start edge.
// Backpressure: none; start_i is only asserted by the owner while idle or on done_o.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   start_i, ptype_i       begin a phase of the given kind (write address/data or status read)
//   use_gap_i              append GAP CS-high cycles to the phase
//   cs_n_o, wr_n_o, rd_n_o bus strobes, active low
//   oe_o                   host drives data (write phases, CS-low window only)
//   sample_o               high during the last strobe-low cycle of a read
//   done_o                 high during the last cycle of the phase
module ym3438_bus_strobe
  import ym3438_host_pkg::*;
#(
  parameter int SETUP = 1,
  parameter int PULSE = 4,
  parameter int GAP   = 2
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   start_i,
  input  phase_e ptype_i,
  input  logic   use_gap_i,
  output logic   cs_n_o,
  output logic   wr_n_o,
  output logic   rd_n_o,
  output logic   oe_o,
  output logic   sample_o,
  output logic   done_o
);

  // Positions within a phase are counted from 1; 0 means no phase running.
  localparam logic [15:0] P_STROBE_FIRST = 16'(SETUP + 1);
  localparam logic [15:0] P_STROBE_LAST  = 16'(SETUP + PULSE);
  localparam logic [15:0] P_HOLD         = 16'(SETUP + PULSE + 1);
  localparam logic [15:0] P_LEN_GAP      = 16'(SETUP + PULSE + 1 + GAP);

  logic [15:0] pos_q, pos_d;
  phase_e      ptype_q, ptype_d;
  logic        gap_q, gap_d;
  logic [15:0] len_cur, len_d;
  logic        in_cs, in_strobe, is_read;
  logic        cs_n_q, wr_n_q, rd_n_q, oe_q, sample_q, done_q;

  always_comb begin
    ptype_d = start_i ? ptype_i : ptype_q;
    gap_d   = start_i ? use_gap_i : gap_q;
    len_cur = gap_q ? P_LEN_GAP : P_HOLD;
    len_d   = gap_d ? P_LEN_GAP : P_HOLD;

    if (start_i) begin
      pos_d = 16'd1;
    end else if (pos_q == 16'd0 || pos_q >= len_cur) begin
      pos_d = 16'd0;
    end else begin
      pos_d = pos_q + 16'd1;
    end

    // Outputs are computed from the next position so they are registered
    // yet line up with the cycle the position describes.
    in_cs     = (pos_d != 16'd0) && (pos_d <= P_HOLD);
    in_strobe = (pos_d >= P_STROBE_FIRST) && (pos_d <= P_STROBE_LAST);
    is_read   = (ptype_d == PH_RD_STATUS);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pos_q    <= 16'd0;
      ptype_q  <= PH_WR_ADDR;
      gap_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      oe_q     <= 1'b0;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      ptype_q  <= ptype_d;
      gap_q    <= gap_d;
      cs_n_q   <= !in_cs;
      wr_n_q   <= !(in_strobe && !is_read);
      rd_n_q   <= !(in_strobe && is_read);
      oe_q     <= in_cs && !is_read;
      sample_q <= (pos_d == P_STROBE_LAST) && is_read;
      done_q   <= (pos_d != 16'd0) && (pos_d == len_d);
    end
  end

  assign cs_n_o   = cs_n_q;
  assign wr_n_o   = wr_n_q;
  assign rd_n_o   = rd_n_q;
  assign oe_o     = oe_q;
  assign sample_o = sample_q;
  assign done_o   = done_q;

endmodule

// File: rtl/ym3438_host_writer.sv
// Host bus initiator: turns one register write into address + data WR phases, then optional busy polling.
// Latency: 16 cycles per write without polling (defaults); each poll read SETUP+PULSE+1, re-poll adds GAP.
// Backpressure: req_ready only while idle; requester holds req_valid until accepted, no internal queue.
// Ports:
//   MCLK, IC                     clock, synchronous active-low reset
//   req_valid/req_ready          write request handshake; req_port/req_addr/req_data latched on accept
//   CS, WR, RD, ADDRESS          chip bus control, strobes active low
//   DATA_o, DATA_oe, STATUS_i    bus data out / drive enable, status read back (bit 7 busy)
//   busy, timeout_err            transaction in progress, one-cycle poll give-up pulse
module ym3438_host_writer
  import ym3438_host_pkg::*;
#(
  parameter int SETUP     = 1,
  parameter int PULSE     = 4,
  parameter int GAP       = 2,
  parameter int BUSY_POLL = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic       MCLK,
  input  logic       IC,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_port,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       CS,
  output logic       WR,
  output logic       RD,
  output logic [1:0] ADDRESS,
  output logic [7:0] DATA_o,
  output logic       DATA_oe,
  input  logic [7:0] STATUS_i,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [15:0] GAP_C     = 16'(GAP);

  state_e      state_q, state_d;
  logic        port_q, port_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  poll_cnt_q, poll_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        stat_q, stat_d;
  logic [1:0]  addr_bus_q, addr_bus_d;
  logic [7:0]  data_bus_q, data_bus_d;
  logic        ready_q, busy_q, terr_q, terr_d;

  logic        start;
  phase_e      ptype;
  logic        use_gap;
  logic        ph_done, ph_sample;

  // Only the busy bit of the status byte matters here.
  logic unused_status;
  assign unused_status = ^STATUS_i[6:0];

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    data_d     = data_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    stat_d     = stat_q;
    terr_d     = 1'b0;
    start      = 1'b0;
    ptype      = PH_WR_ADDR;
    use_gap    = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          start      = 1'b1;
          ptype      = PH_WR_ADDR;
          port_d     = req_port;
          data_d     = req_data;
          poll_cnt_d = 8'd0;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ph_done) begin
          start   = 1'b1;
          ptype   = PH_WR_DATA;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (ph_done) begin
          if (BUSY_POLL != 0) begin
            start   = 1'b1;
            ptype   = PH_RD_STATUS;
            use_gap = 1'b0;
            state_d = ST_POLL;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_POLL: begin
        if (ph_sample) begin
          stat_d     = STATUS_i[BUSY_BIT];
          poll_cnt_d = poll_cnt_q + 8'd1;
        end
        // Decision is taken at the end of the hold cycle, after the sample.
        if (ph_done) begin
          if (!stat_q) begin
            state_d = ST_IDLE;
          end else if (poll_cnt_q < TIMEOUT_C) begin
            gap_cnt_d = 16'd1;
            state_d   = ST_POLL_GAP;
          end else begin
            terr_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_POLL_GAP: begin
        if (gap_cnt_q >= GAP_C) begin
          start   = 1'b1;
          ptype   = PH_RD_STATUS;
          use_gap = 1'b0;
          state_d = ST_POLL;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address/data bus values are loaded together with the phase start.
  always_comb begin
    addr_bus_d = addr_bus_q;
    data_bus_d = data_bus_q;
    if (start) begin
      case (ptype)
        PH_WR_ADDR: begin
          addr_bus_d = {req_port, ADDR_A0_ADDR};
          data_bus_d = req_addr;
        end
        PH_WR_DATA: begin
          addr_bus_d = {port_q, ADDR_A0_DATA};
          data_bus_d = data_q;
        end
        default: begin
          addr_bus_d = 2'b00;
          data_bus_d = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge MCLK) begin
    if (!IC) begin
      state_q    <= ST_IDLE;
      port_q     <= 1'b0;
      data_q     <= 8'h00;
      poll_cnt_q <= 8'd0;
      gap_cnt_q  <= 16'd0;
      stat_q     <= 1'b0;
      addr_bus_q <= 2'b00;
      data_bus_q <= 8'h00;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      data_q     <= data_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      stat_q     <= stat_d;
      addr_bus_q <= addr_bus_d;
      data_bus_q <= data_bus_d;
      ready_q    <= (state_d == ST_IDLE);
      busy_q     <= (state_d != ST_IDLE);
      terr_q     <= terr_d;
    end
  end

  ym3438_bus_strobe #(
    .SETUP (SETUP),
    .PULSE (PULSE),
    .GAP   (GAP)
  ) u_strobe (
    .clk_i     (MCLK),
    .rst_ni    (IC),
    .start_i   (start),
    .ptype_i   (ptype),
    .use_gap_i (use_gap),
    .cs_n_o    (CS),
    .wr_n_o    (WR),
    .rd_n_o    (RD),
    .oe_o      (DATA_oe),
    .sample_o  (ph_sample),
    .done_o    (ph_done)
  );

  assign req_ready   = ready_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign ADDRESS     = addr_bus_q;
  assign DATA_o      = data_bus_q;

endmodule

// File: tb/tb_ym3438_host_writer.sv
// Bench for ym3438_host_writer: three instances (no polling, polling, TIMEOUT=3) on a shared stimulus set.
// Latency: n/a.
// Backpressure: requests are held until req_ready is seen.
module tb_ym3438_host_writer;

  logic       MCLK = 1'b0;
  logic       IC = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_port = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic [7:0] status;
  int         sel = 0;
  logic       stuck = 1'b0;

  logic       vld_w [3];
  logic       rdy_w [3];
  logic       cs_w [3];
  logic       wr_w [3];
  logic       rd_w [3];
  logic [1:0] addr_w [3];
  logic [7:0] dat_w [3];
  logic       oe_w [3];
  logic       busy_w [3];
  logic       terr_w [3];

  logic       o_rdy, o_cs, o_wr, o_rd, o_oe, o_busy, o_terr;
  logic [1:0] o_addr;
  logic [7:0] o_dat;

  int checks = 0;
  int failures = 0;

  logic [9:0] wq [$];
  int rd_total = 0, wr_total = 0, terr_total = 0, cs_run = 0;
  int rd_base = 0;
  logic terr_rdy = 1'b0;
  logic prev_wr = 1'b1, prev_rd = 1'b1;

  always #5 MCLK = ~MCLK;

  assign vld_w[0] = req_valid && (sel == 0);
  assign vld_w[1] = req_valid && (sel == 1);
  assign vld_w[2] = req_valid && (sel == 2);

  assign o_rdy  = rdy_w[sel];
  assign o_cs   = cs_w[sel];
  assign o_wr   = wr_w[sel];
  assign o_rd   = rd_w[sel];
  assign o_addr = addr_w[sel];
  assign o_dat  = dat_w[sel];
  assign o_oe   = oe_w[sel];
  assign o_busy = busy_w[sel];
  assign o_terr = terr_w[sel];

  // Chip model: busy for the first three reads of a poll sequence, or forever when stuck.
  assign status = (stuck || (rd_total - rd_base) <= 3) ? 8'h80 : 8'h00;

  ym3438_host_writer #(.BUSY_POLL(0)) dut0 (
    .MCLK(MCLK), .IC(IC), .req_valid(vld_w[0]), .req_ready(rdy_w[0]), .req_port(req_port),
    .req_addr(req_addr), .req_data(req_data), .CS(cs_w[0]), .WR(wr_w[0]), .RD(rd_w[0]),
    .ADDRESS(addr_w[0]), .DATA_o(dat_w[0]), .DATA_oe(oe_w[0]), .STATUS_i(status),
    .busy(busy_w[0]), .timeout_err(terr_w[0]));

  ym3438_host_writer #(.BUSY_POLL(1)) dut1 (
    .MCLK(MCLK), .IC(IC), .req_valid(vld_w[1]), .req_ready(rdy_w[1]), .req_port(req_port),
    .req_addr(req_addr), .req_data(req_data), .CS(cs_w[1]), .WR(wr_w[1]), .RD(rd_w[1]),
    .ADDRESS(addr_w[1]), .DATA_o(dat_w[1]), .DATA_oe(oe_w[1]), .STATUS_i(status),
    .busy(busy_w[1]), .timeout_err(terr_w[1]));

  ym3438_host_writer #(.BUSY_POLL(1), .TIMEOUT(3)) dut2 (
    .MCLK(MCLK), .IC(IC), .req_valid(vld_w[2]), .req_ready(rdy_w[2]), .req_port(req_port),
    .req_addr(req_addr), .req_data(req_data), .CS(cs_w[2]), .WR(wr_w[2]), .RD(rd_w[2]),
    .ADDRESS(addr_w[2]), .DATA_o(dat_w[2]), .DATA_oe(oe_w[2]), .STATUS_i(status),
    .busy(busy_w[2]), .timeout_err(terr_w[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: pops the scoreboard on each WR falling edge and tracks RD/CS/timeout activity.
  always @(negedge MCLK) begin
    if (!o_wr && prev_wr) begin
      wr_total++;
      cs_run = 0;
      if (wq.size() == 0) begin
        chk("wr_unexpected", {22'd0, o_addr, o_dat}, 32'hFFFF_FFFF);
      end else begin
        chk("wr_bus", {21'd0, o_oe, o_addr, o_dat}, {21'd0, 1'b1, wq.pop_front()});
      end
    end
    if (!o_rd && prev_rd) begin
      chk("poll_cs_gap", cs_run, 2);
      chk("poll_bus", {21'd0, o_oe, o_addr, o_cs}, 32'd0);
      rd_total++;
      cs_run = 0;
    end
    if (o_cs) cs_run++;
    if (!o_wr && !o_rd) chk("wr_rd_both_low", 1, 0);
    if (o_terr) begin
      terr_total++;
      terr_rdy = o_rdy;
    end
    prev_wr = o_wr;
    prev_rd = o_rd;
  end

  task automatic step();
    @(negedge MCLK);
    #1;
  endtask

  task automatic wait_rdy();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (o_rdy) seen = 1'b1;
      else step();
    end
    if (!seen) chk("rdy_wait_expired", 0, 1);
  endtask

  task automatic send(input logic p, input logic [7:0] a, input logic [7:0] d);
    wait_rdy();
    req_port = p;
    req_addr = a;
    req_data = d;
    req_valid = 1'b1;
    wq.push_back({p, 1'b0, a});
    wq.push_back({p, 1'b1, d});
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    logic [16:0] wr_m, cs_m, rdy_m, oe_m, busy_m;
    int base_rd, base_terr, base_wr, acc, c0, c1;

    // Reset values
    repeat (3) step();
    chk("reset_outputs", {19'd0, o_cs, o_wr, o_rd, o_addr, o_dat},
        {19'd0, 1'b1, 1'b1, 1'b1, 2'b00, 8'h00});
    chk("reset_flags", {28'd0, o_oe, o_busy, o_rdy, o_terr}, 32'd0);
    IC = 1'b1;
    step();
    chk("ready_after_reset", {31'd0, o_rdy}, 1);

    // Cycle-exact write, port 0, no polling
    sel = 0;
    req_port = 1'b0; req_addr = 8'h28; req_data = 8'hF0; req_valid = 1'b1;
    wq.push_back({2'b00, 8'h28});
    wq.push_back({2'b01, 8'hF0});
    wr_m = '0; cs_m = '0; rdy_m = '0; oe_m = '0; busy_m = '0;
    for (int k = 1; k <= 17; k++) begin
      step();
      req_valid = 1'b0;
      wr_m[k-1] = !o_wr;
      cs_m[k-1] = !o_cs;
      rdy_m[k-1] = o_rdy;
      oe_m[k-1] = o_oe;
      busy_m[k-1] = o_busy;
    end
    chk("wr_low_cycles", {15'd0, wr_m}, 32'h0000_1E1E);
    chk("cs_low_cycles", {15'd0, cs_m}, 32'h0000_3F3F);
    chk("oe_cycles", {15'd0, oe_m}, 32'h0000_3F3F);
    chk("busy_cycles", {15'd0, busy_m}, 32'h0000_FFFF);
    chk("ready_cycle17", {15'd0, rdy_m}, 32'h0001_0000);

    // Port 1 write
    send(1'b1, 8'h30, 8'h71);
    wait_rdy();

    // Busy for 3 polls then clear
    sel = 1;
    step();
    rd_base = rd_total;
    base_terr = terr_total;
    send(1'b0, 8'hB4, 8'hC0);
    wait_rdy();
    step();
    chk("poll_rd_count", rd_total - rd_base, 4);
    chk("poll_no_timeout", terr_total - base_terr, 0);
    chk("poll_busy_low", {31'd0, o_busy}, 0);

    // Stuck busy with TIMEOUT=3
    sel = 2;
    stuck = 1'b1;
    step();
    base_rd = rd_total;
    base_terr = terr_total;
    send(1'b1, 8'hA0, 8'h5A);
    wait_rdy();
    step();
    chk("timeout_rd_count", rd_total - base_rd, 3);
    chk("timeout_pulse_cycles", terr_total - base_terr, 1);
    chk("timeout_ready", {31'd0, terr_rdy}, 1);
    stuck = 1'b0;

    // Reset during the data-phase WR pulse
    sel = 0;
    step();
    base_wr = wr_total;
    send(1'b0, 8'h11, 8'h22);
    for (int i = 0; i < 100 && (wr_total - base_wr) < 2; i++) step();
    chk("midreset_reached_data", wr_total - base_wr, 2);
    IC = 1'b0;
    step();
    chk("midreset_outputs", {27'd0, o_cs, o_wr, o_rd, o_oe, o_busy}, {27'd0, 5'b11100});
    IC = 1'b1;
    step();
    send(1'b0, 8'h40, 8'h55);
    wait_rdy();
    chk("after_reset_write", wr_total - base_wr, 4);

    // Back-to-back with req_valid held high
    step();
    acc = 0; c0 = 0; c1 = 0;
    req_port = 1'b1; req_addr = 8'hA4; req_data = 8'h22; req_valid = 1'b1;
    wq.push_back({2'b10, 8'hA4});
    wq.push_back({2'b11, 8'h22});
    for (int i = 0; i < 200 && acc < 2; i++) begin
      if (o_rdy && req_valid) begin
        acc++;
        if (acc == 1) c0 = i; else c1 = i;
      end
      step();
      if (acc == 1 && i == c0) begin
        req_port = 1'b0; req_addr = 8'h2B; req_data = 8'h80;
        wq.push_back({2'b00, 8'h2B});
        wq.push_back({2'b01, 8'h80});
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", acc, 2);
    chk("b2b_spacing", c1 - c0, 17);
    wait_rdy();
    step();

    chk("scoreboard_empty", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
